// File: rtl/uart_tx_fifo_if.sv
// Producer-side 4-phase req/ack channel feeding the UART transmitter FIFO.
// The producer drives req and data; the transmitter answers with ack.
interface uart_tx_fifo_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  async_tx_d_req;
    logic [DATA_WIDTH-1:0] async_tx_d;
    logic                  async_tx_d_ack;

    modport master (
        output async_tx_d_req,
        output async_tx_d,
        input  async_tx_d_ack
    );

    modport slave (
        input  async_tx_d_req,
        input  async_tx_d,
        output async_tx_d_ack
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small word FIFO fed by an asynchronous 4-phase producer.
// Frames are sent LSB first, optional parity and second stop bit, back-to-back when data waits.
module uart_tx_fifo #(
    parameter int  FREQ       = 100_000,
    parameter int  BAUD_RATE  = 9600,
    parameter int  DATA_WIDTH = 8,
    parameter int  FIFO_DEPTH = 4,
    parameter int  SYNC_STAGE = 2,
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    uart_tx_fifo_if.slave    s_prod,
    input  logic [3:0]       i_conf,
    output logic             o_tx,
    output logic             o_busy,
    output logic [LVL_W-1:0] o_fifo_level,
    output logic             o_frame_done
);
    localparam int BIT_CYCLES = FREQ / BAUD_RATE;
    localparam int BAUD_W     = $clog2(BIT_CYCLES);
    localparam int BIT_W      = $clog2(DATA_WIDTH);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    logic [SYNC_STAGE-1:0] r_sync;
    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;

    state_t                r_state;
    logic                  r_tx;
    logic                  r_frame_done;
    logic [BAUD_W-1:0]     r_baud;
    logic [BIT_W-1:0]      r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [3:0]            r_fconf;
    logic                  r_par;

    logic                  w_req_s;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_bit_end;
    logic                  w_last_stop;
    logic [DATA_WIDTH-1:0] w_head;

    always_ff @(posedge i_clock) begin
        if (i_reset) r_sync[0] <= 1'b0;
        else         r_sync[0] <= s_prod.async_tx_d_req;
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGE; gi++) begin : g_sync
            always_ff @(posedge i_clock) begin
                if (i_reset) r_sync[gi] <= 1'b0;
                else         r_sync[gi] <= r_sync[gi-1];
            end
        end
    endgenerate

    assign w_req_s = r_sync[SYNC_STAGE-1];
    assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_empty = (r_level == '0);
    // Fullness is judged on the registered level, so a same-cycle pop never frees a slot early.
    assign w_push  = w_req_s & ~r_ack & ~w_full;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge i_clock) begin
        if (w_push) r_mem[r_wr_ptr] <= s_prod.async_tx_d;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ack    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_level <= r_level + LVL_W'(1);
            else if (!w_push && w_pop) r_level <= r_level - LVL_W'(1);
            if (w_push)                r_ack <= 1'b1;
            else if (!w_req_s && r_ack) r_ack <= 1'b0;
        end
    end

    assign w_bit_end   = (r_baud == BAUD_W'(BIT_CYCLES - 1));
    assign w_last_stop = (r_state == S_STOP2) || (r_state == S_STOP1 && !r_fconf[1]);
    assign w_pop       = i_conf[3] & ~w_empty &
                         ((r_state == S_IDLE) | (w_last_stop & w_bit_end));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_tx         <= 1'b1;
            r_frame_done <= 1'b0;
            r_baud       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_fconf      <= '0;
            r_par        <= 1'b0;
        end else begin
            // Raised one cycle early so the pulse lands in the last cycle of the last stop bit.
            r_frame_done <= w_last_stop && (r_baud == BAUD_W'(BIT_CYCLES - 2));
            if (w_pop) begin
                r_state <= S_START;
                r_tx    <= 1'b0;
                r_baud  <= '0;
                r_shift <= w_head;
                r_fconf <= i_conf;
                r_par   <= (^w_head) ^ i_conf[2];
            end else if (r_state == S_IDLE) begin
                r_tx <= 1'b1;
            end else begin
                r_baud <= w_bit_end ? '0 : r_baud + BAUD_W'(1);
                if (w_bit_end) begin
                    case (r_state)
                        S_START: begin
                            r_state <= S_DATA;
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_bit   <= '0;
                        end
                        S_DATA: begin
                            if (r_bit == BIT_W'(DATA_WIDTH - 1)) begin
                                r_state <= r_fconf[0] ? S_PARITY : S_STOP1;
                                r_tx    <= r_fconf[0] ? r_par : 1'b1;
                            end else begin
                                r_bit   <= r_bit + BIT_W'(1);
                                r_tx    <= r_shift[0];
                                r_shift <= r_shift >> 1;
                            end
                        end
                        S_PARITY: begin
                            r_state <= S_STOP1;
                            r_tx    <= 1'b1;
                        end
                        S_STOP1: begin
                            r_state <= r_fconf[1] ? S_STOP2 : S_IDLE;
                            r_tx    <= 1'b1;
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign s_prod.async_tx_d_ack = r_ack;
    assign o_tx         = r_tx;
    assign o_busy       = (r_state != S_IDLE);
    assign o_fifo_level = r_level;
    assign o_frame_done = r_frame_done;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised and directed bench for uart_tx_fifo: a line monitor decodes every frame and
// checks it against words queued by the producer, with bit values derived from UART framing rules.
module tb_uart_tx_fifo;
    localparam int DW    = 8;
    localparam int BC    = 100_000 / 9600;
    localparam int SYNC  = 2;
    localparam int LVL_W = $clog2(4 + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       conf = 4'b0000;
    logic             tx;
    logic             busy;
    logic [LVL_W-1:0] level;
    logic             frame_done;

    uart_tx_fifo_if #(.DATA_WIDTH(DW)) prod_if ();

    uart_tx_fifo #(
        .FREQ(100_000), .BAUD_RATE(9600), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .SYNC_STAGE(SYNC)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .s_prod(prod_if),
        .i_conf(conf),
        .o_tx(tx),
        .o_busy(busy),
        .o_fifo_level(level),
        .o_frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [DW-1:0] exp_q[$];
    int          start_q[$];
    int          last_len = 0;
    int          last_par = 0;
    int          lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line monitor: decodes a frame from its start bit, compares against the scoreboard head.
    logic [3:0]    m_fc;
    logic [DW-1:0] m_word;
    logic          m_ebits [0:15];
    int            m_nbits, m_total, m_done_at, m_idx;
    bit            m_bad, m_dbad, m_abort;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                m_fc = conf;
                start_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    m_word = '0;
                end else begin
                    m_word = exp_q[0];
                end
                m_nbits = 2 + DW + int'(m_fc[0]) + int'(m_fc[1]);
                m_total = m_nbits * BC;
                for (int i = 0; i < 16; i++) m_ebits[i] = 1'b1;
                m_ebits[0] = 1'b0;
                for (int i = 0; i < DW; i++) m_ebits[1+i] = m_word[i];
                if (m_fc[0]) m_ebits[1+DW] = logic'(($countones(m_word) % 2 == 1) ^ m_fc[2]);
                m_bad = 0; m_dbad = 0; m_abort = 0; m_done_at = -1;
                for (int c = 0; c < m_total; c++) begin
                    if (c > 0) @(negedge clk);
                    if (rst) begin
                        m_abort = 1;
                        break;
                    end
                    m_idx = c / BC;
                    if (tx !== m_ebits[m_idx]) m_bad = 1;
                    if (frame_done !== (c == m_total - 1)) m_dbad = 1;
                    if (frame_done === 1'b1 && m_done_at < 0) m_done_at = c;
                    if (m_fc[0] && m_idx == 1 + DW && (c % BC) == BC / 2) last_par = int'(tx);
                end
                if (!m_abort) begin
                    chk($sformatf("frame_bits_word_%02h", m_word), int'(m_bad), 0);
                    chk("frame_done_position", int'(m_dbad), 0);
                    last_len = m_done_at + 1;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] w, output int l);
        @(negedge clk);
        prod_if.async_tx_d     = w;
        prod_if.async_tx_d_req = 1'b1;
        l = 0;
        for (int k = 0; k < 8000; k++) begin
            @(negedge clk);
            l++;
            if (prod_if.async_tx_d_ack === 1'b1) break;
        end
        if (prod_if.async_tx_d_ack !== 1'b1) chk("ack_rise_timeout", 0, 1);
        exp_q.push_back(w);
        $display("send word %02h acked after %0d cycles", w, l);
        prod_if.async_tx_d_req = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (prod_if.async_tx_d_ack === 1'b0) break;
        end
        if (prod_if.async_tx_d_ack !== 1'b0) chk("ack_fall_timeout", 1, 0);
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && busy === 1'b0 && level == 0) break;
        end
        if (k >= 20000) chk("drain_timeout", k, 0);
    endtask

    task automatic send_five();
        int l;
        for (int i = 0; i < 5; i++) send(8'(8'h10 + i * 8'h11), l);
    endtask

    initial begin
        int s0;
        int nw;
        int gap;
        prod_if.async_tx_d_req = 1'b0;
        prod_if.async_tx_d     = '0;
        repeat (3) @(negedge clk);
        chk("reset_tx", int'(tx), 1);
        chk("reset_ack", int'(prod_if.async_tx_d_ack), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_level", int'(level), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        rst = 1'b0;

        // 8N1, 0xA5
        conf = 4'b1000;
        send(8'hA5, lat);
        chk("ack_latency", lat, SYNC + 1);
        drain();
        chk("len_8n1", last_len, 100);

        // Odd then even parity on 0x03
        conf = 4'b1101;
        send(8'h03, lat);
        drain();
        chk("odd_parity_bit", last_par, 1);
        chk("len_parity", last_len, 110);
        conf = 4'b1001;
        send(8'h03, lat);
        drain();
        chk("even_parity_bit", last_par, 0);

        // Two stop bits
        conf = 4'b1010;
        send(8'hFF, lat);
        drain();
        chk("len_stop2", last_len, 110);

        // FIFO fill with transmitter disabled, then release
        conf = 4'b0000;
        fork
            send_five();
        join_none
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (level == 4) break;
        end
        repeat (40) @(negedge clk);
        chk("full_level", int'(level), 4);
        chk("full_ack_held", int'(prod_if.async_tx_d_ack), 0);
        chk("full_not_busy", int'(busy), 0);
        s0 = start_q.size();
        conf = 4'b1000;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (prod_if.async_tx_d_ack === 1'b1) break;
        end
        chk("fifth_ack_after_pop", int'(prod_if.async_tx_d_ack), 1);
        wait fork;
        drain();
        chk("b2b_frame_count", start_q.size() - s0, 5);
        for (int i = 1; i < 5; i++)
            if (s0 + i < start_q.size())
                chk($sformatf("b2b_gap_%0d", i), start_q[s0+i] - start_q[s0+i-1], 100);

        // Reset during data phase with a new request held high
        send(8'h3C, lat);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx === 1'b0) break;
        end
        repeat (35) @(negedge clk);
        rst = 1'b1;
        prod_if.async_tx_d     = 8'h5A;
        prod_if.async_tx_d_req = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_reset_tx", int'(tx), 1);
        chk("mid_reset_busy", int'(busy), 0);
        chk("mid_reset_level", int'(level), 0);
        chk("mid_reset_ack", int'(prod_if.async_tx_d_ack), 0);
        @(negedge clk);
        rst = 1'b0;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            lat++;
            if (prod_if.async_tx_d_ack === 1'b1) break;
        end
        chk("post_reset_ack_latency", lat, SYNC + 1);
        exp_q.push_back(8'h5A);
        prod_if.async_tx_d_req = 1'b0;
        drain();

        // Randomised phases: conf fixed per phase, random words and gaps
        for (int p = 0; p < 4; p++) begin
            conf = {1'b1, 3'($urandom_range(0, 7))};
            nw = $urandom_range(3, 7);
            for (int i = 0; i < nw; i++) begin
                gap = $urandom_range(0, 30);
                repeat (gap) @(negedge clk);
                send(8'($urandom), lat);
            end
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end
endmodule
